// File: rtl/cpu_types_pkg.sv
// Shared CPU types: data words, register selects, opcodes and the enums used
// by the write-back/retire stage.
package cpu_types_pkg;

  typedef logic [31:0] word_t;
  typedef logic [4:0]  regbits_t;

  typedef enum logic [5:0] {
    RTYPE = 6'h00,
    J     = 6'h02,
    JAL   = 6'h03,
    BEQ   = 6'h04,
    ADDIU = 6'h09,
    LW    = 6'h23,
    SW    = 6'h2B,
    HALT  = 6'h3F
  } opcode_t;

  typedef enum logic [1:0] {RD_RT, RD_RD, RD_RA, RD_NONE} regdst_t;

  typedef enum logic [1:0] {WB_RUN, WB_FLUSH, WB_HALTED} wb_state_t;

  localparam regbits_t REG_ZERO = 5'd0;
  localparam regbits_t REG_RA   = 5'd31;

endpackage

// File: rtl/wb_halt_fsm.sv
// Halt sequencer: RUN until HALT retires, FLUSH until the dcache reports done,
// then HALTED until reset. Outputs decode straight from the state register.
module wb_halt_fsm
  import cpu_types_pkg::*;
(
  input  logic CLK,
  input  logic nRST,
  input  logic i_halt_ret,
  input  logic i_flush_done,
  output logic o_in_run,
  output logic o_dcache_flush,
  output logic o_halt
);

  wb_state_t r_state, w_next;

  always_ff @(posedge CLK) begin
    if (!nRST) r_state <= WB_RUN;
    else       r_state <= w_next;
  end

  // flush_done only matters once FLUSH is the registered state
  always_comb begin
    w_next = r_state;
    case (r_state)
      WB_RUN:    if (i_halt_ret)   w_next = WB_FLUSH;
      WB_FLUSH:  if (i_flush_done) w_next = WB_HALTED;
      WB_HALTED: w_next = WB_HALTED;
      default:   w_next = WB_RUN;
    endcase
  end

  assign o_in_run       = (r_state == WB_RUN);
  assign o_dcache_flush = (r_state == WB_FLUSH);
  assign o_halt         = (r_state == WB_HALTED);

endmodule

// File: rtl/wb_retire_unit.sv
// WB-stage consumer: register-file write port, one-cycle forward copy,
// saturating retire counter and the HALT/flush sequencer.
module wb_retire_unit
  import cpu_types_pkg::*;
#(
  parameter int CNT_W  = 32,
  parameter int PC_INC = 4
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             wb_enable,
  input  word_t            Output_Port_WB,
  input  word_t            dmemload_WB,
  input  logic             memtoReg_WB,
  input  logic             RegWr_WB,
  input  logic [1:0]       RegDst_WB,
  input  opcode_t          opcode_WB,
  input  word_t            instr_WB,
  input  word_t            imemaddr_WB,
  input  logic             flush_done,
  output logic             WEN,
  output regbits_t         wsel,
  output word_t            wdat,
  output logic             dcache_flush,
  output logic             halt,
  output logic             fwd_valid,
  output regbits_t         fwd_reg,
  output word_t            fwd_data,
  output logic [CNT_W-1:0] retired
);

  logic       w_in_run, w_ret, w_is_halt;
  regdst_t    w_dst;
  logic [CNT_W-1:0] r_retired;

  assign w_dst     = regdst_t'(RegDst_WB);
  assign w_is_halt = (opcode_WB == HALT);
  // an all-zero instruction word is a bubble
  assign w_ret     = wb_enable & (instr_WB != '0) & w_in_run;

  wb_halt_fsm u_fsm (
    .CLK           (CLK),
    .nRST          (nRST),
    .i_halt_ret    (w_ret & w_is_halt),
    .i_flush_done  (flush_done),
    .o_in_run      (w_in_run),
    .o_dcache_flush(dcache_flush),
    .o_halt        (halt)
  );

  always_comb begin
    wsel = REG_ZERO;
    case (w_dst)
      RD_RT:   wsel = instr_WB[20:16];
      RD_RD:   wsel = instr_WB[15:11];
      RD_RA:   wsel = REG_RA;
      default: wsel = REG_ZERO;
    endcase
  end

  always_comb begin
    if (opcode_WB == JAL) wdat = imemaddr_WB + word_t'(PC_INC);
    else if (memtoReg_WB) wdat = dmemload_WB;
    else                  wdat = Output_Port_WB;
  end

  assign WEN = nRST & w_ret & RegWr_WB & (w_dst != RD_NONE) &
               (wsel != REG_ZERO) & ~w_is_halt;

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      fwd_valid <= 1'b0;
      fwd_reg   <= REG_ZERO;
      fwd_data  <= '0;
      r_retired <= '0;
    end else begin
      fwd_valid <= WEN;
      fwd_reg   <= wsel;
      fwd_data  <= wdat;
      if (w_ret && (r_retired != '1)) r_retired <= r_retired + CNT_W'(1);
    end
  end

  assign retired = r_retired;

endmodule

// File: tb/tb_wb_retire_unit.sv
// Randomized bench for wb_retire_unit against a behavioural model; a second
// narrow-counter instance shares the stimulus to exercise saturation.
module tb_wb_retire_unit;
  import cpu_types_pkg::*;

  logic        CLK, nRST, en, mtr, regwr, fd;
  logic [1:0]  rdst;
  opcode_t     opc;
  logic [31:0] outp, dl, instr, pc;

  logic        wen, dflush, hlt, fv;
  logic [4:0]  ws, freg;
  logic [31:0] wd, fdat, ret32;
  logic        s_wen, s_dflush, s_hlt, s_fv;
  logic [4:0]  s_ws, s_freg;
  logic [31:0] s_wd, s_fdat;
  logic [3:0]  ret4;

  wb_retire_unit dut (
    .CLK(CLK), .nRST(nRST), .wb_enable(en), .Output_Port_WB(outp),
    .dmemload_WB(dl), .memtoReg_WB(mtr), .RegWr_WB(regwr), .RegDst_WB(rdst),
    .opcode_WB(opc), .instr_WB(instr), .imemaddr_WB(pc), .flush_done(fd),
    .WEN(wen), .wsel(ws), .wdat(wd), .dcache_flush(dflush), .halt(hlt),
    .fwd_valid(fv), .fwd_reg(freg), .fwd_data(fdat), .retired(ret32)
  );

  wb_retire_unit #(.CNT_W(4)) dut_sat (
    .CLK(CLK), .nRST(nRST), .wb_enable(en), .Output_Port_WB(outp),
    .dmemload_WB(dl), .memtoReg_WB(mtr), .RegWr_WB(regwr), .RegDst_WB(rdst),
    .opcode_WB(opc), .instr_WB(instr), .imemaddr_WB(pc), .flush_done(fd),
    .WEN(s_wen), .wsel(s_ws), .wdat(s_wd), .dcache_flush(s_dflush), .halt(s_hlt),
    .fwd_valid(s_fv), .fwd_reg(s_freg), .fwd_data(s_fdat), .retired(ret4)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  // reference state: what has been retired/forwarded and where the halt sequence is
  bit          m_fv, m_flush, m_halted;
  logic [4:0]  m_freg;
  logic [31:0] m_fdat;
  longint      m_cnt;
  int          m_cnt4;

  task automatic cyc();
    bit          e_ret, e_wen;
    logic [4:0]  e_ws;
    logic [31:0] e_wd;
    @(negedge CLK);
    e_ret = nRST && en && (instr != 0) && !m_flush && !m_halted;
    case (rdst)
      2'd0:    e_ws = instr[20:16];
      2'd1:    e_ws = instr[15:11];
      2'd2:    e_ws = 5'd31;
      default: e_ws = 5'd0;
    endcase
    e_wd  = (opc == JAL) ? pc + 32'd4 : (mtr ? dl : outp);
    e_wen = e_ret && regwr && (rdst != 2'd3) && (e_ws != 0) && (opc != HALT);
    chk("wen", 32'(wen), 32'(e_wen));
    chk("wen_sat", 32'(s_wen), 32'(e_wen));
    if (e_wen) begin
      chk("wsel", 32'(ws), 32'(e_ws));
      chk("wdat", wd, e_wd);
    end
    chk("dcache_flush", 32'(dflush), 32'(m_flush));
    chk("halt", 32'(hlt), 32'(m_halted));
    chk("halt_sat", 32'(s_hlt), 32'(m_halted));
    chk("fwd_valid", 32'(fv), 32'(m_fv));
    if (m_fv) begin
      chk("fwd_reg", 32'(freg), 32'(m_freg));
      chk("fwd_data", fdat, m_fdat);
    end
    chk("retired", ret32, 32'(m_cnt));
    chk("retired_sat", 32'(ret4), 32'(m_cnt4));
    @(posedge CLK);
    if (!nRST) begin
      m_fv = 0; m_freg = 0; m_fdat = 0; m_cnt = 0; m_cnt4 = 0;
      m_flush = 0; m_halted = 0;
    end else begin
      m_fv = e_wen; m_freg = e_ws; m_fdat = e_wd;
      if (e_ret) begin
        if (m_cnt < 64'hFFFF_FFFF) m_cnt++;
        if (m_cnt4 < 15) m_cnt4++;
      end
      if (m_flush && fd) begin m_flush = 0; m_halted = 1; end
      else if (e_ret && opc == HALT) m_flush = 1;
    end
    #1;
  endtask

  task automatic drv(input bit e, input opcode_t o, input logic [31:0] ins,
                     input bit rw, input logic [1:0] rd, input bit m,
                     input logic [31:0] op, input logic [31:0] d,
                     input logic [31:0] p, input bit f);
    en = e; opc = o; instr = ins; regwr = rw; rdst = rd; mtr = m;
    outp = op; dl = d; pc = p; fd = f;
    cyc();
  endtask

  localparam logic [31:0] ADDU_R5 = {6'h00, 5'd1, 5'd2, 5'd5, 5'd0, 6'h21};
  localparam logic [31:0] ADDU_R0 = {6'h00, 5'd1, 5'd2, 5'd0, 5'd0, 6'h21};
  localparam logic [31:0] LW_R9   = {6'h23, 5'd3, 5'd9, 16'h0010};
  localparam logic [31:0] JAL_W   = {6'h03, 26'h40};
  localparam logic [31:0] HALT_W  = 32'hFFFF_FFFF;

  task automatic rand_cyc();
    opcode_t ops[7] = '{RTYPE, J, JAL, BEQ, ADDIU, LW, SW};
    nRST  = ($urandom_range(0, 59) != 0);
    en    = ($urandom_range(0, 4) != 0);
    opc   = ($urandom_range(0, 29) == 0) ? HALT : ops[$urandom_range(0, 6)];
    instr = ($urandom_range(0, 7) == 0) ? 32'h0 : $urandom;
    regwr = 1'($urandom);
    rdst  = 2'($urandom);
    mtr   = 1'($urandom);
    outp  = $urandom; dl = $urandom; pc = $urandom;
    fd    = ($urandom_range(0, 3) == 0);
    cyc();
  endtask

  initial begin
    nRST = 0;
    drv(0, RTYPE, 0, 0, 0, 0, 0, 0, 0, 0);
    drv(0, RTYPE, 0, 0, 0, 0, 0, 0, 0, 0);
    nRST = 1;
    drv(1, RTYPE, ADDU_R5, 1, 2'd1, 0, 32'h1234, 32'h55, 32'h40, 0);
    chk("addu_fwd_data", fdat, 32'h1234);
    drv(1, LW,    LW_R9,   1, 2'd0, 1, 32'h77, 32'hDEADBEEF, 32'h44, 0);
    drv(1, JAL,   JAL_W,   1, 2'd2, 0, 32'h99, 32'h88, 32'h100, 0);
    drv(1, RTYPE, ADDU_R0, 1, 2'd1, 0, 32'hABCD, 0, 32'h104, 0);
    drv(1, RTYPE, 32'h0,   1, 2'd1, 0, 32'h1, 0, 32'h108, 0);
    drv(0, RTYPE, ADDU_R5, 1, 2'd1, 0, 32'h5, 0, 32'h10C, 0);
    // flush_done together with the retiring HALT must not skip FLUSH
    drv(1, HALT,  HALT_W,  1, 2'd1, 0, 32'h0, 0, 32'h110, 1);
    drv(1, RTYPE, ADDU_R5, 1, 2'd1, 0, 32'h6, 0, 32'h114, 0);
    drv(1, RTYPE, ADDU_R5, 1, 2'd1, 0, 32'h7, 0, 32'h118, 1);
    for (int i = 0; i < 20; i++)
      drv(1, RTYPE, ADDU_R5, 1, 2'd1, 0, 32'h8, 0, 32'h11C, 0);
    nRST = 0;
    drv(1, RTYPE, ADDU_R5, 1, 2'd1, 0, 32'h9, 0, 32'h120, 0);
    nRST = 1;
    drv(1, HALT,  HALT_W,  1, 2'd1, 0, 32'h0, 0, 32'h124, 0);
    drv(1, RTYPE, ADDU_R5, 1, 2'd1, 0, 32'hA, 0, 32'h128, 0);
    nRST = 0;
    drv(1, RTYPE, ADDU_R5, 1, 2'd1, 0, 32'hB, 0, 32'h12C, 1);
    nRST = 1;
    for (int i = 0; i < 20; i++)
      drv(1, RTYPE, ADDU_R5, 1, 2'd1, 0, 32'hC, 0, 32'h130, 0);
    for (int i = 0; i < 3000; i++) rand_cyc();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
